fm_ram_writeback_ctrl: RTL

// Sequences conv-engine output tiles into the float16 feature-map RAM: optional region zero-clear, then per-beat

---
 rtl/fm_ram_writeback_ctrl_pkg.sv | 32 +++
 rtl/fm_ram_writeback_ctrl_addr_counter.sv | 62 ++++++
 rtl/fm_ram_writeback_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fm_ram_writeback_ctrl_pkg.sv
// Shared widths, derived sizes and FSM state encoding for the feature-map RAM
// write-back controller.
//   DATA_WIDTH        float16 word width
//   PARA_Y            words per RAM row group (address step per beat)
//   PARA_KERNEL       output kernels per beat
//   WRITE_ADDR_WIDTH  RAM write address width (address wraps at 2^W)
//   FM_SIZE_WIDTH     output feature-map size width
//   BEAT_CNT_WIDTH    beat counter width
package fm_ram_writeback_ctrl_pkg;

   localparam int DATA_WIDTH       = 16;
   localparam int PARA_Y           = 3;
   localparam int PARA_KERNEL      = 2;
   localparam int WRITE_ADDR_WIDTH = 12;
   localparam int FM_SIZE_WIDTH    = 8;
   localparam int BEAT_CNT_WIDTH   = 12;
   localparam int PARA_WIDTH       = PARA_Y * PARA_KERNEL * DATA_WIDTH;

   typedef logic [WRITE_ADDR_WIDTH-1:0] wr_addr_t;
   typedef logic [BEAT_CNT_WIDTH-1:0]   beat_cnt_t;
   typedef logic [PARA_WIDTH-1:0]       para_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ZERO    = 3'd1,
      ST_RUN     = 3'd2,
      ST_ADD_CAP = 3'd3,
      ST_ADD_WB  = 3'd4,
      ST_FIN     = 3'd5
   } wb_state_e;

endpackage

// File: rtl/fm_ram_writeback_ctrl_addr_counter.sv
// fm_wb_addr_counter: para-write address and beat counter for one job.
//   clk, rst    clock, async active-high reset
//   load        load base address / beat total, clear beat count
//   load_base   first para-write index
//   load_beats  beats in the job
//   step        one beat accepted: address += PARA_Y, count += 1
//   cur_addr    address for the next accepted beat
//   last_beat   the next accepted beat is the final one
//   all_done    every beat of the job has been accepted
module fm_wb_addr_counter
   import fm_ram_writeback_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load,
   input  wr_addr_t  load_base,
   input  beat_cnt_t load_beats,
   input  logic      step,
   output wr_addr_t  cur_addr,
   output logic      last_beat,
   output logic      all_done
);

   wr_addr_t  addr_q, addr_d;
   beat_cnt_t cnt_q, cnt_d;
   beat_cnt_t beats_q, beats_d;
   beat_cnt_t cnt_inc;

   assign cnt_inc = cnt_q + BEAT_CNT_WIDTH'(1);

   always_comb begin
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      beats_d = beats_q;
      if (load) begin
         addr_d  = load_base;
         cnt_d   = '0;
         beats_d = load_beats;
      end else if (step) begin
         // natural wrap of the address is intended
         addr_d = addr_q + WRITE_ADDR_WIDTH'(PARA_Y);
         cnt_d  = cnt_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         cnt_q   <= '0;
         beats_q <= '0;
      end else begin
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         beats_q <= beats_d;
      end
   end

   assign cur_addr  = addr_q;
   assign last_beat = (cnt_inc == beats_q);
   assign all_done  = (cnt_q == beats_q);

endmodule

// File: rtl/fm_ram_writeback_ctrl.sv
// fm_ram_writeback_ctrl: sequences conv-engine output beats into the float16
// feature-map RAM. Optional one-shot region zero-clear, then one para write per
// beat, either overwrite (1 beat/cycle) or accumulate using the RAM's 2-cycle
// add (operand capture edge, result write-back edge; 1 beat/2 cycles).
// Ports: cfg_* job configuration latched on cfg_start in IDLE; s_valid/s_ready/
// s_data beat stream; ram_* RAM write-port controls; ram_write_ready checked the
// cycle after every add write-back; busy/done/err job status. All outputs are
// registered and reset to 0.
//
// state      | meaning
// IDLE       | waiting for cfg_start
// ZERO       | one-cycle zero-clear pulse of the latched range
// RUN        | accepting beats; overwrite writes issued here
// ADD_CAP    | accumulate: RAM captures operands, no beat accepted
// ADD_WB     | accumulate: RAM writes sum back; next beat may be accepted
// FIN        | last write finishing; done pulses on the way to IDLE
module fm_ram_writeback_ctrl
   import fm_ram_writeback_ctrl_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_start,
   input  logic                        cfg_accumulate,
   input  logic [WRITE_ADDR_WIDTH-1:0] cfg_zero_start,
   input  logic [WRITE_ADDR_WIDTH-1:0] cfg_zero_end,
   input  logic [WRITE_ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [BEAT_CNT_WIDTH-1:0]   cfg_beats,
   input  logic [FM_SIZE_WIDTH-1:0]    cfg_fm_out_size,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [PARA_WIDTH-1:0]       s_data,
   output logic                        ram_ena_zero_w,
   output logic [WRITE_ADDR_WIDTH-1:0] ram_zero_start_addr,
   output logic [WRITE_ADDR_WIDTH-1:0] ram_zero_end_addr,
   output logic                        ram_ena_para_w,
   output logic                        ram_ena_add_write,
   output logic [WRITE_ADDR_WIDTH-1:0] ram_addr_para_write,
   output logic [FM_SIZE_WIDTH-1:0]    ram_fm_out_size,
   output logic [PARA_WIDTH-1:0]       ram_para_din,
   input  logic                        ram_write_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   wb_state_e                  state_q, state_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       err_q, err_d;
   logic                       s_ready_q, s_ready_d;
   logic                       ena_zero_q, ena_zero_d;
   logic                       ena_para_q, ena_para_d;
   logic                       add_wr_q, add_wr_d;
   logic                       acc_q, acc_d;
   logic                       wb_chk_q, wb_chk_d;
   wr_addr_t                   addr_q, addr_d;
   wr_addr_t                   zs_q, zs_d;
   wr_addr_t                   ze_q, ze_d;
   logic [FM_SIZE_WIDTH-1:0]   fm_q, fm_d;
   para_t                      din_q, din_d;

   wr_addr_t cur_addr;
   logic     last_beat, all_done;
   logic     cnt_load, cnt_step;
   logic     hs;

   assign hs = s_valid && s_ready_q;

   fm_wb_addr_counter u_addr_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load),
      .load_base  (cfg_base_addr),
      .load_beats (cfg_beats),
      .step       (cnt_step),
      .cur_addr   (cur_addr),
      .last_beat  (last_beat),
      .all_done   (all_done)
   );

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      s_ready_d  = 1'b0;
      ena_zero_d = 1'b0;
      ena_para_d = 1'b0;
      add_wr_d   = add_wr_q;
      acc_d      = acc_q;
      wb_chk_d   = 1'b0;
      addr_d     = addr_q;
      zs_d       = zs_q;
      ze_d       = ze_q;
      fm_d       = fm_q;
      din_d      = din_q;
      cnt_load   = 1'b0;
      cnt_step   = 1'b0;

      // RAM must acknowledge the add write-back one cycle after ADD_WB
      if (wb_chk_q && !ram_write_ready) err_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               cnt_load = 1'b1;
               busy_d   = 1'b1;
               err_d    = 1'b0;
               acc_d    = cfg_accumulate;
               // a job with no beats never issues an add write
               add_wr_d = cfg_accumulate && (cfg_beats != '0);
               zs_d     = cfg_zero_start;
               ze_d     = cfg_zero_end;
               fm_d     = cfg_fm_out_size;
               if (cfg_zero_end > cfg_zero_start) begin
                  state_d    = ST_ZERO;
                  ena_zero_d = 1'b1;
               end else if (cfg_beats == '0) begin
                  state_d = ST_FIN;
               end else begin
                  state_d   = ST_RUN;
                  s_ready_d = 1'b1;
               end
            end
         end
         ST_ZERO: begin
            if (all_done) begin
               state_d = ST_FIN;
            end else begin
               state_d   = ST_RUN;
               s_ready_d = 1'b1;
            end
         end
         ST_RUN: begin
            s_ready_d = 1'b1;
            if (hs) begin
               din_d      = s_data;
               addr_d     = cur_addr;
               cnt_step   = 1'b1;
               ena_para_d = 1'b1;
               if (acc_q) begin
                  state_d   = ST_ADD_CAP;
                  s_ready_d = 1'b0;
               end else if (last_beat) begin
                  state_d   = ST_FIN;
                  s_ready_d = 1'b0;
               end
            end
         end
         ST_ADD_CAP: begin
            ena_para_d = 1'b1;
            state_d    = ST_ADD_WB;
            s_ready_d  = !all_done;
         end
         ST_ADD_WB: begin
            wb_chk_d = 1'b1;
            if (hs) begin
               // back-to-back add: enable stays high through the next capture
               din_d      = s_data;
               addr_d     = cur_addr;
               cnt_step   = 1'b1;
               ena_para_d = 1'b1;
               state_d    = ST_ADD_CAP;
            end else if (all_done) begin
               state_d = ST_FIN;
            end else begin
               state_d   = ST_RUN;
               s_ready_d = 1'b1;
            end
         end
         ST_FIN: begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            add_wr_d = 1'b0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         s_ready_q  <= 1'b0;
         ena_zero_q <= 1'b0;
         ena_para_q <= 1'b0;
         add_wr_q   <= 1'b0;
         acc_q      <= 1'b0;
         wb_chk_q   <= 1'b0;
         addr_q     <= '0;
         zs_q       <= '0;
         ze_q       <= '0;
         fm_q       <= '0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         s_ready_q  <= s_ready_d;
         ena_zero_q <= ena_zero_d;
         ena_para_q <= ena_para_d;
         add_wr_q   <= add_wr_d;
         acc_q      <= acc_d;
         wb_chk_q   <= wb_chk_d;
         addr_q     <= addr_d;
         zs_q       <= zs_d;
         ze_q       <= ze_d;
         fm_q       <= fm_d;
         din_q      <= din_d;
      end
   end

   assign s_ready             = s_ready_q;
   assign ram_ena_zero_w      = ena_zero_q;
   assign ram_zero_start_addr = zs_q;
   assign ram_zero_end_addr   = ze_q;
   assign ram_ena_para_w      = ena_para_q;
   assign ram_ena_add_write   = add_wr_q;
   assign ram_addr_para_write = addr_q;
   assign ram_fm_out_size     = fm_q;
   assign ram_para_din        = din_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign err                 = err_q;

endmodule
